// File: rtl/branch_redirect.sv
// Oldest-first branch mispredict arbiter: one fetch redirect plus a
// one-cycle kill mask over the commit ring slots younger than the branch.
module branch_redirect #(
  parameter int RV       = 64,
  parameter int NCOMMIT  = 32,
  parameter int LNCOMMIT = 5,
  parameter int BDEC     = 4,
  parameter int NBR      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NBR-1:0]          br_enable,
  input  logic [NBR*(RV-1)-1:0]   br_dest,
  input  logic [NBR*LNCOMMIT-1:0] br_addr,
  input  logic [NBR-1:0]          br_short,
  input  logic [NBR*(BDEC-1)-1:0] br_dec,
  input  logic [LNCOMMIT-1:0]     commit_head,
  input  logic [LNCOMMIT-1:0]     commit_tail,
  input  logic                    commit_full,
  output logic                    redirect_valid,
  input  logic                    redirect_ready,
  output logic [RV-2:0]           redirect_pc,
  output logic [LNCOMMIT-1:0]     redirect_addr,
  output logic                    redirect_short,
  output logic [BDEC-2:0]         redirect_dec,
  output logic [NCOMMIT-1:0]      commit_kill
);

  logic                r_valid;
  logic [RV-2:0]       r_pc;
  logic [LNCOMMIT-1:0] r_addr;
  logic                r_short;
  logic [BDEC-2:0]     r_dec;
  logic [NCOMMIT-1:0]  r_kill;

  logic                w_sel_v;
  logic [LNCOMMIT-1:0] w_sel_age;
  logic [RV-2:0]       w_sel_pc;
  logic [LNCOMMIT-1:0] w_sel_addr;
  logic                w_sel_short;
  logic [BDEC-2:0]     w_sel_dec;
  logic [LNCOMMIT-1:0] w_p_age;
  logic [LNCOMMIT:0]   w_occ;
  logic [NCOMMIT-1:0]  w_kmask;
  logic                w_xfer;
  logic                w_cap;

  assign w_xfer  = r_valid & redirect_ready;
  assign w_p_age = r_addr - commit_head;
  assign w_occ   = commit_full ? (LNCOMMIT+1)'(NCOMMIT)
                               : {1'b0, commit_tail - commit_head};

  // strict < keeps the lowest index on equal age
  always_comb begin
    logic [LNCOMMIT-1:0] a;
    logic [LNCOMMIT-1:0] age;
    w_sel_v     = 1'b0;
    w_sel_age   = '0;
    w_sel_pc    = '0;
    w_sel_addr  = '0;
    w_sel_short = 1'b0;
    w_sel_dec   = '0;
    for (int i = 0; i < NBR; i++) begin
      a   = br_addr[i*LNCOMMIT +: LNCOMMIT];
      age = a - commit_head;
      if (br_enable[i] && !r_kill[a] &&
          (!w_sel_v || age < w_sel_age)) begin
        w_sel_v     = 1'b1;
        w_sel_age   = age;
        w_sel_pc    = br_dest[i*(RV-1) +: RV-1];
        w_sel_addr  = a;
        w_sel_short = br_short[i];
        w_sel_dec   = br_dec[i*(BDEC-1) +: BDEC-1];
      end
    end
  end

  assign w_cap = w_sel_v &
                 (!r_valid | w_xfer | (w_sel_age < w_p_age));

  always_comb begin
    logic [LNCOMMIT-1:0] sage;
    w_kmask = '0;
    for (int s = 0; s < NCOMMIT; s++) begin
      sage = LNCOMMIT'(s) - commit_head;
      w_kmask[s] = (sage > w_sel_age) && ({1'b0, sage} < w_occ);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_addr  <= '0;
      r_short <= 1'b0;
      r_dec   <= '0;
      r_kill  <= '0;
    end else begin
      r_kill <= '0;
      if (w_cap) begin
        r_valid <= 1'b1;
        r_pc    <= w_sel_pc;
        r_addr  <= w_sel_addr;
        r_short <= w_sel_short;
        r_dec   <= w_sel_dec;
        r_kill  <= w_kmask;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign redirect_valid = r_valid;
  assign redirect_pc    = r_pc;
  assign redirect_addr  = r_addr;
  assign redirect_short = r_short;
  assign redirect_dec   = r_dec;
  assign commit_kill    = r_kill;

endmodule

// File: tb/tb_branch_redirect.sv
// Directed plus randomized checks of branch_redirect against an
// age/occupancy reference model.
module tb_branch_redirect;
  localparam int RV = 64;
  localparam int NC = 32;
  localparam int LN = 5;
  localparam int BD = 4;
  localparam int NB = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NB-1:0]     br_enable;
  logic [NB*(RV-1)-1:0] br_dest;
  logic [NB*LN-1:0]  br_addr;
  logic [NB-1:0]     br_short;
  logic [NB*(BD-1)-1:0] br_dec;
  logic [LN-1:0]     commit_head;
  logic [LN-1:0]     commit_tail;
  logic              commit_full;
  logic              redirect_valid;
  logic              redirect_ready;
  logic [RV-2:0]     redirect_pc;
  logic [LN-1:0]     redirect_addr;
  logic              redirect_short;
  logic [BD-2:0]     redirect_dec;
  logic [NC-1:0]     commit_kill;

  int errs = 0;
  int checks = 0;

  logic          m_valid = 1'b0;
  logic [RV-2:0] m_pc = '0;
  int            m_addr = 0;
  logic          m_short = 1'b0;
  logic [BD-2:0] m_dec = '0;
  logic [NC-1:0] m_kill = '0;

  branch_redirect dut (
    .clk(clk), .reset(reset),
    .br_enable(br_enable), .br_dest(br_dest),
    .br_addr(br_addr), .br_short(br_short),
    .br_dec(br_dec), .commit_head(commit_head),
    .commit_tail(commit_tail), .commit_full(commit_full),
    .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc),
    .redirect_addr(redirect_addr),
    .redirect_short(redirect_short),
    .redirect_dec(redirect_dec),
    .commit_kill(commit_kill)
  );

  always #5 clk = ~clk;

  function automatic int age(int s, int h);
    return ((s - h) % NC + NC) % NC;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic unit(int i, int a, logic [RV-2:0] d,
                      logic sh, logic [BD-2:0] dc);
    br_enable[i] = 1'b1;
    br_addr[i*LN +: LN] = LN'(a);
    br_dest[i*(RV-1) +: RV-1] = d;
    br_short[i] = sh;
    br_dec[i*(BD-1) +: BD-1] = dc;
  endtask

  // Advance one clock: predict from the rules, then compare all outputs.
  task automatic step(string tag);
    int h, occ, sel, best, a, slot;
    logic cap;
    logic          n_valid;
    logic [RV-2:0] n_pc;
    int            n_addr;
    logic          n_short;
    logic [BD-2:0] n_dec;
    logic [NC-1:0] n_kill;
    h = int'(commit_head);
    occ = commit_full ? NC : age(int'(commit_tail), h);
    sel = -1;
    best = 0;
    for (int i = 0; i < NB; i++) begin
      a = int'(br_addr[i*LN +: LN]);
      if (br_enable[i] && !m_kill[a] &&
          (sel < 0 || age(a, h) < best)) begin
        sel = i;
        best = age(a, h);
      end
    end
    cap = (sel >= 0) && (!m_valid || redirect_ready ||
                         best < age(m_addr, h));
    n_valid = m_valid; n_pc = m_pc; n_addr = m_addr;
    n_short = m_short; n_dec = m_dec; n_kill = '0;
    if (reset) begin
      n_valid = 0; n_pc = '0; n_addr = 0; n_short = 0; n_dec = '0;
    end else if (cap) begin
      n_valid = 1'b1;
      n_pc = br_dest[sel*(RV-1) +: RV-1];
      n_addr = int'(br_addr[sel*LN +: LN]);
      n_short = br_short[sel];
      n_dec = br_dec[sel*(BD-1) +: BD-1];
      for (int k = best + 1; k < occ; k++) begin
        slot = (h + k) % NC;
        n_kill[slot] = 1'b1;
      end
    end else if (m_valid && redirect_ready) begin
      n_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    m_valid = n_valid; m_pc = n_pc; m_addr = n_addr;
    m_short = n_short; m_dec = n_dec; m_kill = n_kill;
    check({tag, ".valid"}, 64'(redirect_valid), 64'(m_valid));
    check({tag, ".pc"}, 64'(redirect_pc), 64'(m_pc));
    check({tag, ".addr"}, 64'(redirect_addr), 64'(m_addr));
    check({tag, ".short"}, 64'(redirect_short), 64'(m_short));
    check({tag, ".dec"}, 64'(redirect_dec), 64'(m_dec));
    check({tag, ".kill"}, 64'(commit_kill), 64'(m_kill));
  endtask

  task automatic idle();
    br_enable = '0;
  endtask

  initial begin
    reset = 1'b1; br_enable = '0; br_dest = '0; br_addr = '0;
    br_short = '0; br_dec = '0; commit_head = '0; commit_tail = '0;
    commit_full = 1'b0; redirect_ready = 1'b1;
    step("reset");
    check("reset_valid", 64'(redirect_valid), 64'd0);
    reset = 1'b0;

    // single redirect
    commit_head = 5'd3; commit_tail = 5'd10;
    unit(0, 5, 63'h400, 1'b1, 3'd5);
    step("single");
    check("single_pc", 64'(redirect_pc), 64'h400);
    check("single_kill", 64'(commit_kill), 64'h3C0);
    idle();
    step("single_done");
    check("single_clr", 64'(commit_kill), 64'd0);

    // two units, wrap-around
    commit_head = 5'd28; commit_tail = 5'd4;
    unit(0, 2, 63'h111, 1'b0, 3'd1);
    unit(1, 30, 63'h222, 1'b1, 3'd2);
    step("two");
    check("two_addr", 64'(redirect_addr), 64'd30);
    check("two_kill", 64'(commit_kill), 64'h8000000F);
    idle();
    step("two_done");

    // stall then older override, then younger ignored
    redirect_ready = 1'b0;
    commit_head = 5'd8; commit_tail = 5'd20;
    unit(0, 12, 63'h333, 1'b0, 3'd3);
    step("stall");
    check("stall_kill", 64'(commit_kill), 64'h000FE000);
    idle();
    unit(1, 10, 63'h444, 1'b1, 3'd4);
    step("override");
    check("ovr_addr", 64'(redirect_addr), 64'd10);
    check("ovr_kill", 64'(commit_kill), 64'h000FF800);
    idle();
    step("ovr_idle");
    unit(0, 14, 63'h555, 1'b0, 3'd6);
    step("younger");
    check("young_addr", 64'(redirect_addr), 64'd10);
    check("young_kill", 64'(commit_kill), 64'd0);
    idle();
    redirect_ready = 1'b1;
    step("drain");

    // stale report dropped while a transfer happens
    unit(0, 12, 63'h666, 1'b0, 3'd7);
    step("pre_stale");
    unit(0, 13, 63'h777, 1'b1, 3'd0);
    step("stale");
    check("stale_addr", 64'(redirect_addr), 64'd12);
    check("stale_valid", 64'(redirect_valid), 64'd0);
    idle();

    // full ring
    commit_full = 1'b1; commit_head = '0; commit_tail = '0;
    unit(0, 0, 63'h888, 1'b0, 3'd1);
    step("full");
    check("full_kill", 64'(commit_kill), 64'hFFFFFFFE);
    idle(); commit_full = 1'b0;
    step("full_done");

    // reset while stalled with a candidate present
    redirect_ready = 1'b0;
    commit_head = 5'd8; commit_tail = 5'd20;
    unit(0, 12, 63'h999, 1'b1, 3'd2);
    step("rst_pre");
    unit(0, 10, 63'hAAA, 1'b0, 3'd3);
    reset = 1'b1;
    step("rst_mid");
    check("rst_valid", 64'(redirect_valid), 64'd0);
    check("rst_kill", 64'(commit_kill), 64'd0);
    reset = 1'b0; idle();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      br_enable = NB'($urandom_range(0, 3));
      br_addr = NB*LN'($urandom);
      br_dest = {$urandom, $urandom, $urandom, $urandom};
      br_short = NB'($urandom);
      br_dec = NB*(BD-1)'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        commit_head = LN'($urandom);
        commit_tail = LN'($urandom);
      end
      commit_full = ($urandom_range(0, 9) == 0);
      redirect_ready = ($urandom_range(0, 2) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/branch_redirect.md
# branch_redirect

Collects misprediction reports from the NBR branch units, selects the oldest one in program order, and turns it into a single fetch redirect plus a one-cycle kill mask over the commit ring. It sits between the branch units' commit_br_* outputs and the fetch/commit logic. It is the consumer end of the branch-unit redirect interface.

## Interface
Parameters:
- RV, 64, architectural register/PC width; PCs carried as [RV-1:1]
- NCOMMIT, 32, commit ring entries
- LNCOMMIT, 5, log2(NCOMMIT)
- BDEC, 4, width+1 of the decode-slot field carried with a branch
- NBR, 2, number of branch units feeding this block

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- br_enable  in  NBR  unit i reports a mispredict/redirect this cycle
- br_dest  in  NBR*(RV-1)  target PC[RV-1:1]; unit i at [i*(RV-1)+:RV-1]
- br_addr  in  NBR*LNCOMMIT  commit slot of the branch; unit i at [i*LNCOMMIT+:LNCOMMIT]
- br_short  in  NBR  branch was a 2-byte instruction
- br_dec  in  NBR*(BDEC-1)  PC[BDEC-1:1] of the branch
- commit_head  in  LNCOMMIT  oldest occupied ring slot
- commit_tail  in  LNCOMMIT  next slot to be allocated
- commit_full  in  1  ring full (head==tail means full, not empty)
- redirect_valid  out  1  redirect pending for fetch
- redirect_ready  in  1  fetch accepts redirect
- redirect_pc  out  RV-1  target PC[RV-1:1]
- redirect_addr  out  LNCOMMIT  commit slot of the redirecting branch
- redirect_short  out  1  copy of br_short of the selected branch
- redirect_dec  out  BDEC-1  copy of br_dec of the selected branch
- commit_kill  out  NCOMMIT  one-cycle kill pulse, bit per ring slot

## Operation
- Age of slot s = (s - commit_head) mod NCOMMIT, LNCOMMIT-bit wrap arithmetic. Smaller age is older.
- Occupancy occ = commit_full ? NCOMMIT : (commit_tail - commit_head) mod NCOMMIT.
- Candidate i is valid when br_enable[i] is high and commit_kill[br_addr_i] is low. A report from a slot being killed this cycle is stale and is dropped.
- Select the valid candidate with minimum age. On an equal age, the lowest index wins.
- Pending register P holds {pc, addr, short, dec}, with valid = redirect_valid. xfer = redirect_valid & redirect_ready.
- The selected candidate is captured into P when any of the following holds:
  - !redirect_valid
  - xfer
  - age(cand) < age(P.addr), where both ages are computed against the current commit_head
- Otherwise the candidate is discarded, because it is younger than the pending redirect and has already been killed.
- After a capture, redirect_valid=1. Otherwise, when xfer occurs, redirect_valid=0.
- On a capture, the next-cycle commit_kill bit s is 1 for every slot whose age satisfies age(cand) < age < occ. The branch's own slot is never killed. Every other cycle, commit_kill=0.
- redirect_* outputs hold stable while valid and not accepted, unless they are overridden by an older capture.
- Precondition, enforced by the commit unit: the slot held in P does not retire while redirect_valid=1.

## Timing
- Reset: redirect_valid=0, commit_kill=0, redirect_pc=0, redirect_addr=0, redirect_short=0, redirect_dec=0. Reset overrides any same-cycle capture.
- Latency: a br_enable sampled at edge N gives redirect_valid/redirect_* and commit_kill at edge N+1. The kill pulse is exactly 1 cycle long.
- Back-to-back: with xfer and a new candidate in the same cycle, the current redirect transfers and the new one is captured for the next cycle, regardless of age.
- Override while stalled (!redirect_ready): an older candidate replaces P and issues a new kill pulse. A younger or equal-age candidate is ignored and no pulse is issued.
- Wrap-around: age arithmetic must be correct when the branch slot is below commit_head numerically.
- commit_kill is registered. The kill mask uses commit_head, commit_tail and commit_full sampled in the capture cycle.

## Test plan
- Single redirect case:
  - Stimulus: head=3, tail=10, br_enable[0]=1, br_addr=5, br_dest=0x400, redirect_ready=1.
  - Next cycle: redirect_valid=1, redirect_pc=0x400, redirect_addr=5, commit_kill=bits 6..9 only.
  - The cycle after: both outputs are 0.
- Two units in the same cycle:
  - Stimulus: head=28, unit0 addr=2 (age 6), unit1 addr=30 (age 2).
  - Response: unit1 is selected. With tail=4, commit_kill=bits 31,0,1,2,3 (wrap-around).
- Stall then older override:
  - Stimulus: redirect_ready=0, P.addr=12, head=8, then a unit reports addr=10.
  - Response: P.addr becomes 10, a second kill pulse covers bits 11..tail-1, and redirect_valid remains 1.
  - A subsequent report at addr=14 is ignored and produces no pulse.
- Stale report:
  - Stimulus: a report at addr=13 arrives in the cycle commit_kill[13]=1.
  - Response: no capture and no change to redirect_*.
- Full ring:
  - Stimulus: commit_full=1, head=tail=0, branch addr=0.
  - Response: commit_kill=bits 1..31.
- Reset mid-stall:
  - Stimulus: reset asserted with redirect_valid=1 and a candidate present.
  - Response: the next cycle has redirect_valid=0 and commit_kill=0.
